// File: rtl/conv_pkg.sv
// Shared sizing and state encoding for the convolution stream host.
package conv_pkg;
  localparam int T       = 16;
  localparam int X_COUNT = 16;
  localparam int F_COUNT = 8;
  localparam int Y_COUNT = X_COUNT - F_COUNT + 1;
  localparam int ADDR_X  = $clog2(X_COUNT);
  localparam int ADDR_Y  = $clog2(Y_COUNT);

  typedef enum logic [1:0] {LOAD, SEND, RECV, DONE} host_state_t;
endpackage

// File: rtl/stream_buf.sv
// Single-write-port sample buffer; REG_RD selects registered (1) or async (0) read.
module stream_buf #(
  parameter int W      = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter bit REG_RD = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_word;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Addresses beyond the populated depth read as zero.
  always_comb begin
    rd_word = '0;
    if (32'(raddr_i) < DEPTH) rd_word = mem_q[raddr_i];
  end

  if (REG_RD) begin : g_reg_rd
    logic [W-1:0] rdata_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rdata_q <= '0;
      else         rdata_q <= rd_word;
    end
    assign rdata_o = rdata_q;
  end else begin : g_async_rd
    logic unused_rst;
    assign unused_rst = rst_ni;
    assign rdata_o    = rd_word;
  end
endmodule

// File: rtl/conv_stream_host.sv
// Frame loader / x-stream source / y-stream sink for the 1-D conv layer.
// Define CONV_HOST_THROTTLE_EN to limit both streams to one beat per two cycles.
module conv_stream_host
  import conv_pkg::*;
#(
  parameter int T       = conv_pkg::T,
  parameter int X_COUNT = conv_pkg::X_COUNT,
  parameter int F_COUNT = conv_pkg::F_COUNT,
  parameter int Y_COUNT = X_COUNT - F_COUNT + 1,
  parameter int ADDR_X  = $clog2(X_COUNT),
  parameter int ADDR_Y  = $clog2(Y_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [T-1:0]      ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic [T-1:0]      m_data_out_x,
  output logic              m_valid_x,
  input  logic              m_ready_x,
  input  logic [T-1:0]      s_data_in_y,
  input  logic              s_valid_y,
  output logic              s_ready_y,
  input  logic [ADDR_Y-1:0] rd_addr,
  output logic [T-1:0]      rd_data,
  output logic              done,
  input  logic              next
);
  host_state_t       state_q, state_d;
  logic [ADDR_X-1:0] tx_idx_q, tx_idx_d;
  logic [ADDR_Y-1:0] y_idx_q, y_idx_d;
  logic [T-1:0]      tx_word;
  logic              ld_fire, x_fire, y_fire;
  logic              x_gate, y_gate;

`ifdef CONV_HOST_THROTTLE_EN
  logic tog_q, pend_q, gap_q;
  // A stalled valid stays up via pend_q; gap_q keeps a stall-resolved beat from running back-to-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tog_q  <= 1'b0;
      pend_q <= 1'b0;
      gap_q  <= 1'b0;
    end else begin
      tog_q  <= ~tog_q;
      pend_q <= m_valid_x & ~m_ready_x;
      gap_q  <= x_fire;
    end
  end
  assign x_gate = pend_q | (tog_q & ~gap_q);
  assign y_gate = tog_q;
`else
  assign x_gate = 1'b1;
  assign y_gate = 1'b1;
`endif

  assign ld_ready     = (state_q == LOAD);
  assign m_valid_x    = (state_q == SEND) & x_gate;
  assign s_ready_y    = (state_q == RECV) & y_gate;
  assign done         = (state_q == DONE);
  assign m_data_out_x = (state_q == SEND) ? tx_word : '0;

  assign ld_fire = ld_valid & ld_ready;
  assign x_fire  = m_valid_x & m_ready_x;
  assign y_fire  = s_valid_y & s_ready_y;

  always_comb begin
    state_d  = state_q;
    tx_idx_d = tx_idx_q;
    y_idx_d  = y_idx_q;
    case (state_q)
      LOAD: if (ld_fire) begin
        if (tx_idx_q == ADDR_X'(X_COUNT - 1)) begin
          tx_idx_d = '0;
          state_d  = SEND;
        end else tx_idx_d = tx_idx_q + ADDR_X'(1);
      end
      SEND: if (x_fire) begin
        if (tx_idx_q == ADDR_X'(X_COUNT - 1)) begin
          tx_idx_d = '0;
          state_d  = RECV;
        end else tx_idx_d = tx_idx_q + ADDR_X'(1);
      end
      RECV: if (y_fire) begin
        if (y_idx_q == ADDR_Y'(Y_COUNT - 1)) begin
          y_idx_d = '0;
          state_d = DONE;
        end else y_idx_d = y_idx_q + ADDR_Y'(1);
      end
      DONE: if (next) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD;
      tx_idx_q <= '0;
      y_idx_q  <= '0;
    end else begin
      state_q  <= state_d;
      tx_idx_q <= tx_idx_d;
      y_idx_q  <= y_idx_d;
    end
  end

  stream_buf #(.W(T), .DEPTH(X_COUNT), .AW(ADDR_X), .REG_RD(1'b0)) u_txbuf (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (ld_fire),
    .waddr_i (tx_idx_q),
    .wdata_i (ld_data),
    .raddr_i (tx_idx_q),
    .rdata_o (tx_word)
  );

  stream_buf #(.W(T), .DEPTH(Y_COUNT), .AW(ADDR_Y), .REG_RD(1'b1)) u_ybuf (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (y_fire),
    .waddr_i (y_idx_q),
    .wdata_i (s_data_in_y),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );
endmodule

// File: tb/tb_conv_stream_host.sv
// Directed bench for conv_stream_host with an x-stream scoreboard queue and a y-buffer model.
module tb_conv_stream_host;
  import conv_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic signed [T-1:0]     ld_data = '0;
  logic                    ld_valid = 1'b0;
  logic                    ld_ready;
  logic signed [T-1:0]     m_data_out_x;
  logic                    m_valid_x;
  logic                    m_ready_x = 1'b0;
  logic signed [T-1:0]     s_data_in_y = '0;
  logic                    s_valid_y = 1'b0;
  logic                    s_ready_y;
  logic [ADDR_Y-1:0]       rd_addr = '0;
  logic signed [T-1:0]     rd_data;
  logic                    done;
  logic                    next = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic signed [T-1:0] xq [$];
  logic signed [T-1:0] frame  [X_COUNT];
  logic signed [T-1:0] yv     [Y_COUNT];
  logic signed [T-1:0] ymodel [Y_COUNT];

  conv_stream_host dut (
    .clk          (clk),
    .reset        (reset),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .m_data_out_x (m_data_out_x),
    .m_valid_x    (m_valid_x),
    .m_ready_x    (m_ready_x),
    .s_data_in_y  (s_data_in_y),
    .s_valid_y    (s_valid_y),
    .s_ready_y    (s_ready_y),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .done         (done),
    .next         (next)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_ready"},  32'(ld_ready), 32'd1);
    check({tag, "_m_valid_x"}, 32'(m_valid_x), 32'd0);
    check({tag, "_x_data"},    32'(m_data_out_x), 32'd0);
    check({tag, "_s_ready_y"}, 32'(s_ready_y), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_rd_data"},   32'(rd_data), 32'd0);
  endtask

  task automatic load_frame();
    for (int i = 0; i < X_COUNT; i++) begin
      int g = 0;
      @(negedge clk);
      while (!ld_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      ld_valid = 1'b1;
      ld_data  = frame[i];
      xq.push_back(frame[i]);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    check("load_end_ld_ready", 32'(ld_ready), 32'd0);
`ifndef CONV_HOST_THROTTLE_EN
    check("load_end_x_valid", 32'(m_valid_x), 32'd1);
`endif
  endtask

  task automatic drain_x(input int nbeats, input int stall_beat, input int stall_len);
    int beat = 0;
    int stalled = 0;
    int g = 0;
    while (beat < nbeats && g < 400) begin
      @(negedge clk);
      g++;
      if (m_valid_x && xq.size() > 0) begin
        check("x_data", 32'(m_data_out_x), 32'(xq[0]));
        if (beat == stall_beat && stalled < stall_len) begin
          m_ready_x = 1'b0;
          stalled++;
        end else begin
          m_ready_x = 1'b1;
          void'(xq.pop_front());
          beat++;
        end
      end else begin
        m_ready_x = 1'b0;
      end
    end
    check("x_beats", beat, nbeats);
    @(negedge clk);
    m_ready_x = 1'b0;
    if (nbeats == X_COUNT) begin
      check("x_end_valid", 32'(m_valid_x), 32'd0);
      check("x_sb_empty", xq.size(), 0);
`ifndef CONV_HOST_THROTTLE_EN
      check("x_end_recv", 32'(s_ready_y), 32'd1);
      check("x_cycles", g, nbeats + stall_len);
`endif
    end
  endtask

  task automatic recv_frame();
    int i = 0;
    int g = 0;
    while (i < Y_COUNT && g < 200) begin
      @(negedge clk);
      g++;
      s_valid_y   = 1'b1;
      s_data_in_y = yv[i];
      if (s_ready_y) begin
        ymodel[i] = yv[i];
        i++;
      end
    end
    check("y_beats", i, Y_COUNT);
    @(negedge clk);
    s_valid_y = 1'b0;
    check("y_end_done", 32'(done), 32'd1);
    check("y_end_ready", 32'(s_ready_y), 32'd0);
`ifndef CONV_HOST_THROTTLE_EN
    check("y_cycles", g, Y_COUNT);
`endif
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < (1 << ADDR_Y); a++) begin
      logic signed [T-1:0] exp;
      @(negedge clk);
      rd_addr = a[ADDR_Y-1:0];
      if (a < Y_COUNT) exp = ymodel[a];
      else             exp = '0;
      @(negedge clk);
      check(tag, 32'(rd_data), 32'(exp));
    end
  endtask

  task automatic pulse_next();
    @(negedge clk);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    check("next_done_clear", 32'(done), 32'd0);
    check("next_ld_ready", 32'(ld_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    // Frame 1: ramp 1..16 at full rate, results all 314
    for (int i = 0; i < X_COUNT; i++) frame[i] = T'(i + 1);
    load_frame();
    drain_x(X_COUNT, -1, 0);
    for (int i = 0; i < Y_COUNT; i++) yv[i] = 16'sd314;
    recv_frame();
    readback("rd_f1");

    // DONE holds; y traffic and idle cycles do not disturb it
    repeat (3) begin
      @(negedge clk);
      s_valid_y   = 1'b1;
      s_data_in_y = 16'sd5;
    end
    @(negedge clk);
    s_valid_y = 1'b0;
    check("done_hold", 32'(done), 32'd1);
    pulse_next();

    // y traffic while loading must not reach the result buffer; next ignored here
    for (int k = 0; k < 3; k++) begin
      logic signed [T-1:0] junk [3];
      junk = '{16'sh7fff, 16'sh0000, 16'sh0005};
      @(negedge clk);
      s_valid_y   = 1'b1;
      s_data_in_y = junk[k];
      next        = 1'b1;
    end
    @(negedge clk);
    s_valid_y = 1'b0;
    next      = 1'b0;
    check("load_ignore_ld_ready", 32'(ld_ready), 32'd1);
    readback("rd_ignore");

    // Frame 2: ramp with a 5-cycle stall at beat 3, signed extreme results
    for (int i = 0; i < X_COUNT; i++) frame[i] = T'(i + 1);
    load_frame();
    drain_x(X_COUNT, 3, 5);
    yv = '{16'sh7fff, 16'sh8000, 16'sh0000, 16'sh0001, 16'shffff,
           16'sd314, 16'sd100, -16'sd200, 16'sd12345};
    recv_frame();
    readback("rd_f2");
    pulse_next();

    // Frame 3: random data, reset asserted after 7 x beats
    for (int i = 0; i < X_COUNT; i++) frame[i] = T'($urandom);
    load_frame();
    drain_x(7, -1, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    xq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Frame 4: fresh random frame after reset transmits from beat 0
    for (int i = 0; i < X_COUNT; i++) frame[i] = T'($urandom);
    load_frame();
    drain_x(X_COUNT, -1, 0);
    for (int i = 0; i < Y_COUNT; i++) yv[i] = T'($urandom);
    recv_frame();
    readback("rd_f4");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
